fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage feeding the instruction decoder. It holds the PC and issues single-outstanding requests to a variable-latency instruction memory. It presents each returned instruction with its PC to decode under a valid/ready handshake, and applies redirects (taken branch, jal/jalr, halt self-loop) from the execute stage. Whenever no instruction is valid, the stage presents a NOP (opcode 0001111), so decode always sees a benign instruction.

## Interface
**Parameters**
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - rst_n  in  1  asynchronous active-low reset.
- Instruction memory:
  - imem_req  out  1  one-cycle request pulse.
  - imem_addr  out  32  request address, word-aligned.
  - imem_rvalid  in  1  response strobe; arrives 1 or more cycles after imem_req.
  - imem_rdata  in  32  instruction word, valid with imem_rvalid.
- Redirect from execute:
  - redirect_valid  in  1  PC redirect.
  - redirect_pc  in  32  target; bits [1:0] ignored (forced to 0).
- Decode side:
  - inst  out  32  instruction to decode; 32'h0000000F when inst_valid=0.
  - inst_pc  out  32  PC of inst.
  - inst_valid  out  1  inst/inst_pc hold a live instruction.
  - inst_ready  in  1  decode consumes inst this cycle.
- Status:
  - halted  out  1  halt state reached (see Configuration).

## Operation
- States:
  - IDLE: reset state.
  - REQ: imem_req=1 for exactly one cycle.
  - WAIT: awaiting imem_rvalid.
  - HOLD: inst_valid=1.
  - FLUSH: discarding a stale response.
  - HALT.
- Transitions:
  - IDLE → REQ unconditionally.
  - REQ → WAIT.
  - WAIT + rvalid → HOLD: capture inst=imem_rdata, inst_pc=pc.
  - HOLD + inst_ready → REQ with pc=pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - FLUSH + rvalid → REQ with pending pc; data dropped.
- Redirect has priority over every other event:
  - IDLE: next REQ uses redirect_pc.
  - REQ: the outgoing request is stale → FLUSH, pending pc = redirect_pc.
  - WAIT, no rvalid: → FLUSH.
  - WAIT with rvalid same cycle: response dropped, → REQ with redirect_pc.
  - HOLD: instruction dropped (counts as consumed if inst_ready was also high), → REQ with redirect_pc.
  - FLUSH: pending pc overwritten by newest redirect_pc; stay FLUSH.
  - HALT: ignored.
- imem_rvalid outside WAIT/FLUSH is a protocol error and is ignored.
- Reset mid-transaction: all state cleared immediately; a response arriving after reset release and before the first REQ is ignored.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - inst=32'h0000000F, inst_pc=RESET_PC, inst_valid=0.
  - halted=0; state IDLE.
- All outputs are registered or decoded from the state register only; no combinational path from any input to any output.
- First imem_req appears in the 2nd cycle after rst_n deasserts.
- imem_addr is valid only while imem_req=1.
- Memory latency L means rvalid arrives L cycles after the imem_req cycle. inst_valid rises in the cycle after rvalid.
- Throughput with inst_ready held high: one instruction per L+2 cycles.
- Redirect in cycle N (HOLD/WAIT+rvalid/IDLE): imem_req with redirect_pc in cycle N+1; inst_valid=0 from N+1.

## Configuration
- FETCH_HALT_DETECT_EN:
  - Defined: in HOLD, when inst[6:0]==7'b1111111 and inst_ready=1, the halt instruction is delivered once, then the unit enters HALT.
  - In HALT: no further imem_req, inst_valid=0, halted=1 until reset.
  - Undefined: opcode 1111111 is fetched like any other; halting relies on the redirect to its own PC, so fetch keeps looping. halted is tied 0 and HALT is unreachable.

## Structure
- Package fetch_pkg holds:
  - the state enum;
  - NOP_INST=32'h0000000F;
  - OPC_HALT=7'b1111111;
  - PC_STEP=4.
- One sub-module, fetch_pc_gen: the PC register, pending-redirect register, +4 adder and next-PC mux, with alignment masking. The FSM and output registers stay in fetch_unit.

## Test plan
- Reset release, L=1, inst_ready=1:
  - imem_req with addr 0x0 in the 2nd cycle, then 0x4, 0x8.
  - Each inst_valid pulse carries the matching inst_pc; period is 3 cycles.
- Backpressure: inst_ready=0 for 5 cycles in HOLD → inst/inst_pc stable, no imem_req. On release, next request is at +4.
- Redirect in WAIT with L=4 (target 0x100):
  - FLUSH entered; the stale response is not presented.
  - Next imem_req addr=0x100; two redirects during FLUSH → the last target wins.
- Redirect coincident with rvalid, and redirect_pc=0x203 → response dropped, next request addr=0x200.
- PC wrap: redirect to 0xFFFFFFFC, consume → next addr 0x0.
- With FETCH_HALT_DETECT_EN, return 0x0000007F:
  - delivered once; then halted=1, no imem_req for 20 cycles, redirects ignored.
  - Without the macro: the next request is at +4 and halted stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FLUSH,
    ST_HALT
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_KEEP,
    PC_INC,
    PC_REDIR,
    PC_PEND
  } pc_op_e;

  localparam logic [31:0] NOP_INST = 32'h0000_000F;
  localparam logic [6:0]  OPC_HALT = 7'b1111111;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register, pending-redirect register and next-PC selection.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_op_e      pc_op,
  input  logic        pend_load,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic [31:0] pc_d;
  logic [31:0] target;

  assign target = align_pc(redirect_pc);

  always_comb begin
    pc_d = pc_q;
    case (pc_op)
      PC_INC:   pc_d = pc_q + PC_STEP;   // wraps naturally at 2^32
      PC_REDIR: pc_d = target;
      PC_PEND:  pc_d = pend_q;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= align_pc(RESET_PC);
      pend_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_d;
      if (pend_load) pend_q <= target;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, valid/ready to decode.
// Optional halt detection on opcode 1111111 is enabled by FETCH_HALT_DETECT_EN.
//
// state | meaning
// IDLE  | reset state, next cycle issues a request
// REQ   | imem_req asserted for one cycle
// WAIT  | awaiting imem_rvalid
// HOLD  | inst_valid asserted, waiting for inst_ready
// FLUSH | discarding the response of a redirected request
// HALT  | halt opcode delivered, fetch stopped until reset
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  pc_op_e       pc_op;
  logic         pend_load;
  logic         capture;
  logic [31:0]  pc;
  logic [31:0]  inst_q;
  logic [31:0]  inst_pc_q;

  fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_op       (pc_op),
    .pend_load   (pend_load),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_op     = PC_KEEP;
    pend_load = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect_valid) pc_op = PC_REDIR;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pend_load = 1'b1;
          state_d   = ST_FLUSH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid && imem_rvalid) begin
          pc_op   = PC_REDIR;
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          pend_load = 1'b1;
          state_d   = ST_FLUSH;
        end else if (imem_rvalid) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_op   = PC_REDIR;
          state_d = ST_REQ;
        end else if (inst_ready) begin
`ifdef FETCH_HALT_DETECT_EN
          if (inst_q[6:0] == OPC_HALT) begin
            state_d = ST_HALT;
          end else begin
            pc_op   = PC_INC;
            state_d = ST_REQ;
          end
`else
          pc_op   = PC_INC;
          state_d = ST_REQ;
`endif
        end
      end
      ST_FLUSH: begin
        // a newer redirect keeps us waiting for the same stale response
        if (redirect_valid) begin
          pend_load = 1'b1;
        end else if (imem_rvalid) begin
          pc_op   = PC_PEND;
          state_d = ST_REQ;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      inst_q    <= NOP_INST;
      inst_pc_q <= align_pc(RESET_PC);
    end else begin
      state_q <= state_d;
      if (capture) begin
        inst_q    <= imem_rdata;
        inst_pc_q <= pc;
      end
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_valid ? inst_q : NOP_INST;
  assign inst_pc    = inst_pc_q;
`ifdef FETCH_HALT_DETECT_EN
  assign halted     = (state_q == ST_HALT);
`else
  assign halted     = 1'b0;
`endif

endmodule
